// File: rtl/tft_ctrl_if.sv
// Signal bundle between the TFT timing generator, the pixel generator and the panel pins.
// master = timing generator side, slave = pixel generator / panel side.
interface tft_ctrl_if;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] rgb_tft;
  logic        hsync;
  logic        vsync;
  logic        tft_de;
  logic        tft_clk;
  logic        tft_bl;
  logic        frame_start;

  modport master (
    input  pix_data,
    output pix_x, pix_y, rgb_tft, hsync, vsync, tft_de, tft_clk, tft_bl, frame_start
  );

  modport slave (
    output pix_data,
    input  pix_x, pix_y, rgb_tft, hsync, vsync, tft_de, tft_clk, tft_bl, frame_start
  );
endinterface

// File: rtl/tft_ctrl.sv
// 480x272 RGB565 TFT timing generator: pixel requests run one clock ahead of the
// registered data enable so a 1-cycle pixel generator lines up with the panel.
module tft_ctrl #(
  parameter logic [9:0] H_SYNC  = 10'd41,
  parameter logic [9:0] H_BACK  = 10'd2,
  parameter logic [9:0] H_VALID = 10'd480,
  parameter logic [9:0] H_FRONT = 10'd2,
  parameter logic [9:0] H_TOTAL = 10'd525,
  parameter logic [9:0] V_SYNC  = 10'd10,
  parameter logic [9:0] V_BACK  = 10'd2,
  parameter logic [9:0] V_VALID = 10'd272,
  parameter logic [9:0] V_FRONT = 10'd2,
  parameter logic [9:0] V_TOTAL = 10'd286
) (
  input  logic       tft_clk_9m,
  input  logic       sys_rst,
  tft_ctrl_if.master tft
);

  localparam logic [9:0] HS    = H_SYNC + H_BACK;
  localparam logic [9:0] VS    = V_SYNC + V_BACK;
  localparam logic [9:0] REQ_LO = HS - 10'd1;
  localparam logic [9:0] REQ_HI = HS - 10'd1 + H_VALID;
  localparam logic [9:0] V_HI   = VS + V_VALID;

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       run_q, run_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;
  logic       req_h, act_v, req;

  always_comb begin
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    run_d   = 1'b1;
    fs_d    = 1'b0;
    req_h   = (cnt_h_q >= REQ_LO) && (cnt_h_q < REQ_HI);
    act_v   = (cnt_v_q >= VS) && (cnt_v_q < V_HI);
    req     = req_h && act_v;
    de_d    = req;

    // First clock after reset release: hold 0,0 and mark the start of a fresh frame.
    if (!run_q) begin
      fs_d = 1'b1;
    end else begin
      if (cnt_h_q >= H_TOTAL - 10'd1) begin
        cnt_h_d = 10'd0;
        cnt_v_d = (cnt_v_q >= V_TOTAL - 10'd1) ? 10'd0 : cnt_v_q + 10'd1;
      end else begin
        cnt_h_d = cnt_h_q + 10'd1;
      end
      fs_d = (cnt_h_d == 10'd0) && (cnt_v_d == 10'd0);
    end
  end

  always_ff @(posedge tft_clk_9m) begin
    if (sys_rst) begin
      cnt_h_q <= 10'd0;
      cnt_v_q <= 10'd0;
      run_q   <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      run_q   <= run_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign tft.pix_x       = req ? (cnt_h_q - REQ_LO) : 10'h3FF;
  assign tft.pix_y       = req ? (cnt_v_q - VS) : 10'h3FF;
  assign tft.hsync       = ~(cnt_h_q < H_SYNC);
  assign tft.vsync       = ~(cnt_v_q < V_SYNC);
  assign tft.tft_de      = de_q;
  assign tft.rgb_tft     = de_q ? tft.pix_data : 16'h0000;
  assign tft.tft_clk     = tft_clk_9m;
  assign tft.tft_bl      = ~sys_rst;
  assign tft.frame_start = fs_q;

endmodule

// File: tb/tb_tft_ctrl.sv
// Scoreboard bench for tft_ctrl: a full-size instance and a shrunken-timing instance
// (so whole frames, frame edges and wraps are covered quickly), both with random stimulus.
module tb_tft_ctrl;

  localparam int RUN_CYCLES = 60000;
  localparam int MAX_FAILS  = 50;

  logic clk;
  int   tests;
  int   fails;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        bl;
    logic        rst_seen;
    int          cyc;
  } exp_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int inst, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
      if (fails >= MAX_FAILS) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    // Instance 0 uses the real panel timing; instance 1 a tiny frame of 16x9 clocks.
    localparam int HSY = (gi == 0) ? 41  : 4;
    localparam int HBP = (gi == 0) ? 2   : 2;
    localparam int HV  = (gi == 0) ? 480 : 8;
    localparam int HFP = (gi == 0) ? 2   : 2;
    localparam int VSY = (gi == 0) ? 10  : 2;
    localparam int VBP = (gi == 0) ? 2   : 1;
    localparam int VV  = (gi == 0) ? 272 : 5;
    localparam int VFP = (gi == 0) ? 2   : 1;
    localparam int HT  = HSY + HBP + HV + HFP;
    localparam int VT  = VSY + VBP + VV + VFP;
    localparam int HS  = HSY + HBP;
    localparam int VS  = VSY + VBP;

    logic rst;
    exp_t q[$];

    tft_ctrl_if bus ();

    tft_ctrl #(
      .H_SYNC (10'(HSY)), .H_BACK (10'(HBP)), .H_VALID(10'(HV)), .H_FRONT(10'(HFP)),
      .H_TOTAL(10'(HT)),
      .V_SYNC (10'(VSY)), .V_BACK (10'(VBP)), .V_VALID(10'(VV)), .V_FRONT(10'(VFP)),
      .V_TOTAL(10'(VT))
    ) dut (
      .tft_clk_9m(clk),
      .sys_rst   (rst),
      .tft       (bus)
    );

    // Stimulus + reference model: position p within the frame, from which h and v follow.
    initial begin : stim
      int p, h, v, cyc, rst_hold;
      bit started, fs, fired, prev_req, req, rst_at_edge;
      logic [9:0]  prev_x;
      logic [15:0] pix, rnd;
      exp_t e;
      rst = 1'b1;
      bus.pix_data = 16'h0000;
      p = 0; cyc = 0; rst_hold = 0;
      started = 1'b0; fs = 1'b0; fired = 1'b0; prev_req = 1'b0;
      prev_x = 10'h3FF;
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        rst_at_edge = rst;
        if (rst_at_edge) begin
          p = 0; started = 1'b0; fs = 1'b0;
        end else if (!started) begin
          started = 1'b1; fs = 1'b1;
        end else begin
          p  = (p + 1) % (HT * VT);
          fs = (p == 0);
        end
        h = p % HT;
        v = p / HT;

        if (cyc < 5) begin
          rst = 1'b1;
        end else if (gi == 0) begin
          rst = !fired && (v == 100) && (h == 200);
          if (rst) fired = 1'b1;
        end else begin
          if (rst_hold == 0 && $urandom_range(2999) == 0) rst_hold = $urandom_range(3, 1);
          rst = (rst_hold > 0);
          if (rst_hold > 0) rst_hold--;
        end

        // Pixel generator: registered echo of the previous request, junk during blanking.
        rnd = 16'($urandom);
        if (prev_req) pix = {6'b0, prev_x};
        else if (gi == 0 || $urandom_range(1) == 1) pix = 16'hFEC0;
        else pix = rnd;
        bus.pix_data = pix;

        req = (h >= HS - 1) && (h < HS - 1 + HV) && (v >= VS) && (v < VS + VV);
        e.x   = req ? 10'(h - (HS - 1)) : 10'h3FF;
        e.y   = req ? 10'(v - VS) : 10'h3FF;
        e.de  = (h >= HS) && (h < HS + HV) && (v >= VS) && (v < VS + VV);
        e.rgb = e.de ? pix : 16'h0000;
        e.hs  = (h >= HSY);
        e.vs  = (v >= VSY);
        e.fs  = fs;
        e.bl  = !rst;
        e.rst_seen = rst_at_edge || rst;
        e.cyc = cyc;
        prev_req = req;
        prev_x   = e.x;
        q.push_back(e);
      end
    end

    // Monitor: pops one expectation per cycle and also checks run lengths / frame period.
    initial begin : mon
      int last_fs, hs_run, de_run;
      bit fs_clean, hs_clean, de_clean;
      exp_t e;
      last_fs = 0; hs_run = 0; de_run = 0;
      fs_clean = 1'b0; hs_clean = 1'b0; de_clean = 1'b0;
      forever begin
        @(negedge clk);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("pix_x",       gi, e.cyc, 32'(bus.pix_x),       32'(e.x));
          chk("pix_y",       gi, e.cyc, 32'(bus.pix_y),       32'(e.y));
          chk("rgb_tft",     gi, e.cyc, 32'(bus.rgb_tft),     32'(e.rgb));
          chk("hsync",       gi, e.cyc, 32'(bus.hsync),       32'(e.hs));
          chk("vsync",       gi, e.cyc, 32'(bus.vsync),       32'(e.vs));
          chk("tft_de",      gi, e.cyc, 32'(bus.tft_de),      32'(e.de));
          chk("frame_start", gi, e.cyc, 32'(bus.frame_start), 32'(e.fs));
          chk("tft_bl",      gi, e.cyc, 32'(bus.tft_bl),      32'(e.bl));
          chk("tft_clk",     gi, e.cyc, 32'(bus.tft_clk),     32'(clk));

          if (bus.frame_start === 1'b1) begin
            if (fs_clean) chk("frame_period", gi, e.cyc, 32'(e.cyc - last_fs), 32'(HT * VT));
            last_fs  = e.cyc;
            fs_clean = 1'b1;
          end

          if (bus.hsync === 1'b0) begin
            hs_run++;
          end else begin
            if (hs_run > 0 && hs_clean) chk("hsync_low_len", gi, e.cyc, 32'(hs_run), 32'(HSY));
            hs_run   = 0;
            hs_clean = 1'b1;
          end

          if (bus.tft_de === 1'b1) begin
            de_run++;
          end else begin
            if (de_run > 0 && de_clean) chk("de_len", gi, e.cyc, 32'(de_run), 32'(HV));
            de_run   = 0;
            de_clean = 1'b1;
          end

          if (e.rst_seen) begin
            fs_clean = 1'b0;
            hs_clean = 1'b0;
            de_clean = 1'b0;
          end
        end
      end
    end
  end

  initial begin : main
    tests = 0;
    fails = 0;
    repeat (RUN_CYCLES) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain0", 0, RUN_CYCLES, 32'(g_inst[0].q.size()), 32'd0);
    chk("sb_drain1", 1, RUN_CYCLES, 32'(g_inst[1].q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
